// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Round-robin scheduler sharing one multi-cycle FP8 ALU (add/multiply)
//   between two requesters. Requests are taken over valid/ready. Legal
//   operations launch the ALU with a one-cycle restart pulse and then wait,
//   with a bounded timeout, for the ALU's output-valid. Illegal opcodes are
//   answered at once with an error flag. Every outcome is returned on one
//   tagged response channel.
//
// Ports
//   clock, reset                : rising-edge clock, synchronous active-low reset
//   reqN_valid/ready/a/b/op     : request channel of requester N (N = 0, 1)
//   resp_valid/ready            : response handshake
//   resp_data                   : ALU result (0 on error or timeout)
//   resp_id                     : requester the response belongs to
//   resp_err, resp_timeout      : illegal opcode / ALU never answered
//   alu_a, alu_b, alu_ctrl      : registered operands and opcode to the ALU
//   alu_restart                 : ALU active-high reset (launch pulse)
//   alu_y, alu_valid            : ALU result and is_output_valid
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int TIMEOUT = 15  // legal range 2..255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [3:0] req0_op,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic [3:0] req1_op,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [7:0] resp_data,
    output logic       resp_id,
    output logic       resp_err,
    output logic       resp_timeout,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_ctrl,
    output logic       alu_restart,
    input  logic [7:0] alu_y,
    input  logic       alu_valid
);

    localparam int            CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
    localparam logic [3:0]    OP_ADD  = 4'b0001;
    localparam logic [3:0]    OP_MUL  = 4'b0010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state_q;
    logic          last_grant_q;
    logic [CW-1:0] cnt_q;
    logic [7:0]    alu_a_q;
    logic [7:0]    alu_b_q;
    logic [3:0]    alu_ctrl_q;
    logic [7:0]    resp_data_q;
    logic          resp_id_q;
    logic          resp_err_q;
    logic          resp_timeout_q;

    // Grant selection for the IDLE state.
    logic       grant_valid_d;
    logic       grant_id_d;
    logic [7:0] sel_a_d;
    logic [7:0] sel_b_d;
    logic [3:0] sel_op_d;
    logic       sel_legal_d;
    logic       accept;

    // NOTE: every signal written in always_comb is assigned at the top of the
    // block, so no path through it can leave a value held (no latch).
    always_comb begin
        grant_valid_d = req0_valid | req1_valid;
        grant_id_d    = req1_valid;
        // On a tie the requester that was not served last wins.
        if (req0_valid && req1_valid) begin
            grant_id_d = ~last_grant_q;
        end
        sel_a_d     = grant_id_d ? req1_a  : req0_a;
        sel_b_d     = grant_id_d ? req1_b  : req0_b;
        sel_op_d    = grant_id_d ? req1_op : req0_op;
        sel_legal_d = (sel_op_d == OP_ADD) || (sel_op_d == OP_MUL);
    end

    // Ready is gated by reset so nothing is acknowledged while it is held.
    assign accept     = reset && (state_q == S_IDLE) && grant_valid_d;
    assign req0_ready = accept && !grant_id_d;
    assign req1_ready = accept &&  grant_id_d;

    // The ALU is held in restart for as long as reset is low, not only from
    // the first sampling edge onwards.
    assign alu_restart  = !reset || (state_q == S_LAUNCH);

    assign resp_valid   = (state_q == S_RESP);
    assign resp_data    = resp_data_q;
    assign resp_id      = resp_id_q;
    assign resp_err     = resp_err_q;
    assign resp_timeout = resp_timeout_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_ctrl     = alu_ctrl_q;

    // NOTE: state is updated with non-blocking assignments so every register
    // in this block samples the values from before the edge, independent of
    // statement order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            last_grant_q   <= 1'b1;  // req0 wins the first tie
            cnt_q          <= '0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_ctrl_q     <= '0;
            resp_data_q    <= '0;
            resp_id_q      <= 1'b0;
            resp_err_q     <= 1'b0;
            resp_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_valid_d) begin
                        resp_id_q <= grant_id_d;
                        if (sel_legal_d) begin
                            alu_a_q    <= sel_a_d;
                            alu_b_q    <= sel_b_d;
                            alu_ctrl_q <= sel_op_d;
                            state_q    <= S_LAUNCH;
                        end else begin
                            // Illegal opcode: answer at once, ALU untouched.
                            resp_err_q  <= 1'b1;
                            resp_data_q <= '0;
                            state_q     <= S_RESP;
                        end
                    end
                end
                S_LAUNCH: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // Valid at count 0 may be left over from the previous
                    // operation, so it is only trusted from count 1 onwards.
                    // A valid result beats a simultaneous timeout.
                    if ((cnt_q != '0) && alu_valid) begin
                        resp_data_q <= alu_y;
                        state_q     <= S_RESP;
                    end else if (cnt_q == CNT_MAX) begin
                        resp_data_q    <= '0;
                        resp_timeout_q <= 1'b1;
                        state_q        <= S_RESP;
                    end else begin
                        // Only reached below CNT_MAX, so the count never wraps.
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        last_grant_q   <= resp_id_q;
                        resp_err_q     <= 1'b0;
                        resp_timeout_q <= 1'b0;
                        state_q        <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//   Directed bench for alu_arbiter. A stub ALU answers a fixed table of FP8
//   operations after a programmable latency. It can also stay silent, or
//   pulse valid only in the first cycle after restart. Expected values are
//   hand-computed constants.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int TIMEOUT = 15;

    logic       clock = 1'b0;
    logic       reset;
    logic       req0_valid, req0_ready;
    logic [7:0] req0_a, req0_b;
    logic [3:0] req0_op;
    logic       req1_valid, req1_ready;
    logic [7:0] req1_a, req1_b;
    logic [3:0] req1_op;
    logic       resp_valid, resp_ready;
    logic [7:0] resp_data;
    logic       resp_id, resp_err, resp_timeout;
    logic [7:0] alu_a, alu_b;
    logic [3:0] alu_ctrl;
    logic       alu_restart;
    logic [7:0] alu_y;
    logic       alu_valid;

    int vectors     = 0;
    int miscompares = 0;

    alu_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clock       (clock),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_op     (req0_op),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_op     (req1_op),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_id     (resp_id),
        .resp_err    (resp_err),
        .resp_timeout(resp_timeout),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .alu_restart (alu_restart),
        .alu_y       (alu_y),
        .alu_valid   (alu_valid)
    );

    always #5 clock = ~clock;

    // Cycle index: value seen at a negedge names the current cycle.
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Running count of restart pulses outside reset.
    int restarts = 0;
    always @(posedge clock) if (reset && alu_restart) restarts <= restarts + 1;

    // Stub ALU. Mode 0: valid once `since` reaches stub_lat; mode 1: never
    // valid; mode 2: valid only in the first cycle after restart.
    int stub_mode = 0;
    int stub_lat  = 1;
    int since     = 0;
    always @(posedge clock) begin
        if (alu_restart) since <= 0;
        else if (since < 1000) since <= since + 1;
    end

    always_comb begin
        alu_valid = 1'b0;
        case (stub_mode)
            0:       alu_valid = !alu_restart && (since >= stub_lat);
            1:       alu_valid = 1'b0;
            default: alu_valid = !alu_restart && (since == 0);
        endcase
    end

    function automatic logic [7:0] stub_y(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] c);
        case ({c, a, b})
            {4'b0001, 8'h40, 8'h40}: return 8'h48;
            {4'b0010, 8'h40, 8'h39}: return 8'h41;
            {4'b0001, 8'h28, 8'h10}: return 8'h29;
            {4'b0010, 8'h38, 8'hB8}: return 8'hB8;
            default:                 return 8'hEE;
        endcase
    endfunction

    assign alu_y = stub_y(alu_a, alu_b, alu_ctrl);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit id, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end
    endtask

    // Present a request, return the cycle it is accepted in, drop valid at
    // the following negedge.
    task automatic issue(input bit id, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op, output int t);
        int n;
        logic rdy;
        n = 0;
        t = -1;
        drive(id, a, b, op);
        #1;
        rdy = id ? req1_ready : req0_ready;
        while (!rdy && n < 40) begin
            @(negedge clock);
            #1;
            rdy = id ? req1_ready : req0_ready;
            n++;
        end
        if (rdy) t = cyc;
        else check("accept_wait", rdy, 1'b1);
        @(negedge clock);
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    // Wait (bounded) at negedges for resp_valid, return the cycle it is seen.
    task automatic wait_resp(input int budget, output int t);
        int n;
        n = 0;
        t = -1;
        while (!resp_valid && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (resp_valid) t = cyc;
        else check("resp_wait", resp_valid, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        int t, tr, r0, seen;

        reset      = 1'b0;
        req0_valid = 1'b1;  // shows ready is gated during reset
        req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;
        resp_ready = 1'b1;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clock);
        check("rst_resp_valid",   resp_valid,   1'b0);
        check("rst_resp_data",    resp_data,    8'h00);
        check("rst_resp_id",      resp_id,      1'b0);
        check("rst_resp_err",     resp_err,     1'b0);
        check("rst_resp_timeout", resp_timeout, 1'b0);
        check("rst_alu_a",        alu_a,        8'h00);
        check("rst_alu_b",        alu_b,        8'h00);
        check("rst_alu_ctrl",     alu_ctrl,     4'h0);
        check("rst_req0_ready",   req0_ready,   1'b0);
        check("rst_req1_ready",   req1_ready,   1'b0);
        check("rst_alu_restart",  alu_restart,  1'b1);
        req0_valid = 1'b0;
        reset      = 1'b1;
        @(negedge clock);

        // ---------------- single add ----------------
        r0 = restarts;
        issue(1'b0, 8'h40, 8'h40, 4'b0001, t);
        check("add_launch_restart", alu_restart, 1'b1);
        check("add_alu_a",    alu_a,    8'h40);
        check("add_alu_b",    alu_b,    8'h40);
        check("add_alu_ctrl", alu_ctrl, 4'b0001);
        wait_resp(40, tr);
        check("add_latency", tr - t,   4);
        check("add_data",    resp_data, 8'h48);
        check("add_id",      resp_id,   1'b0);
        check("add_err",     resp_err,  1'b0);
        check("add_tmo",     resp_timeout, 1'b0);
        check("add_restart_pulses", restarts - r0, 1);
        @(negedge clock);
        check("add_resp_done", resp_valid, 1'b0);

        // ---------------- tie after reset: req0 first ----------------
        do_reset();
        stub_lat = 3;
        drive(1'b0, 8'h40, 8'h39, 4'b0010);
        drive(1'b1, 8'h28, 8'h10, 4'b0001);
        #1;
        check("tie1_req0_ready", req0_ready, 1'b1);
        check("tie1_req1_ready", req1_ready, 1'b0);
        t = cyc;
        @(negedge clock);
        req0_valid = 1'b0;
        wait_resp(40, tr);
        check("tie1_a_latency", tr - t,   6);
        check("tie1_a_data",    resp_data, 8'h41);
        check("tie1_a_id",      resp_id,   1'b0);
        @(negedge clock);
        #1;
        check("tie1_b_ready",    req1_ready, 1'b1);
        check("tie1_b_backtoback", cyc - tr, 1);
        t = cyc;
        @(negedge clock);
        req1_valid = 1'b0;
        wait_resp(40, tr);
        check("tie1_b_latency", tr - t,   6);
        check("tie1_b_data",    resp_data, 8'h29);
        check("tie1_b_id",      resp_id,   1'b1);
        @(negedge clock);

        // ---------------- backpressure (req0) ----------------
        stub_lat   = 1;
        resp_ready = 1'b0;
        issue(1'b0, 8'h40, 8'h40, 4'b0001, t);
        drive(1'b0, 8'h28, 8'h10, 4'b0001);  // req0 stays valid throughout
        wait_resp(40, tr);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid",      resp_valid, 1'b1);
            check("bp_data",       resp_data,  8'h48);
            check("bp_id",         resp_id,    1'b0);
            check("bp_req0_ready", req0_ready, 1'b0);
            @(negedge clock);
        end
        resp_ready = 1'b1;
        #1;
        check("bp_release_valid", resp_valid, 1'b1);
        @(negedge clock);
        #1;
        check("bp_next_ready", req0_ready, 1'b1);
        check("bp_idle",       resp_valid, 1'b0);
        t = cyc;
        @(negedge clock);
        req0_valid = 1'b0;
        wait_resp(40, tr);
        check("bp_next_latency", tr - t,   4);
        check("bp_next_data",    resp_data, 8'h29);
        check("bp_next_id",      resp_id,   1'b0);
        @(negedge clock);

        // ---------------- tie with pointer at req0: req1 first ----------------
        drive(1'b0, 8'h38, 8'hB8, 4'b0010);
        drive(1'b1, 8'h40, 8'h40, 4'b0001);
        #1;
        check("tie2_req1_ready", req1_ready, 1'b1);
        check("tie2_req0_ready", req0_ready, 1'b0);
        @(negedge clock);
        req1_valid = 1'b0;
        wait_resp(40, tr);
        check("tie2_a_data", resp_data, 8'h48);
        check("tie2_a_id",   resp_id,   1'b1);
        @(negedge clock);
        #1;
        check("tie2_b_ready", req0_ready, 1'b1);
        @(negedge clock);
        req0_valid = 1'b0;
        wait_resp(40, tr);
        check("tie2_b_data", resp_data, 8'hB8);
        check("tie2_b_id",   resp_id,   1'b0);
        @(negedge clock);

        // ---------------- illegal opcode ----------------
        r0 = restarts;
        issue(1'b1, 8'h12, 8'h34, 4'b0111, t);
        check("ill_valid",    resp_valid,   1'b1);
        check("ill_latency",  cyc - t,      1);
        check("ill_err",      resp_err,     1'b1);
        check("ill_data",     resp_data,    8'h00);
        check("ill_id",       resp_id,      1'b1);
        check("ill_tmo",      resp_timeout, 1'b0);
        check("ill_alu_ctrl", alu_ctrl,     4'b0010);
        check("ill_alu_a",    alu_a,        8'h38);
        @(negedge clock);
        check("ill_no_restart", restarts - r0, 0);
        check("ill_err_clear",  resp_err,      1'b0);

        // ---------------- timeout: ALU silent ----------------
        stub_mode = 1;
        issue(1'b0, 8'h40, 8'h40, 4'b0001, t);
        wait_resp(40, tr);
        check("tmo_latency", tr - t,       TIMEOUT + 3);
        check("tmo_flag",    resp_timeout, 1'b1);
        check("tmo_data",    resp_data,    8'h00);
        check("tmo_err",     resp_err,     1'b0);
        @(negedge clock);
        check("tmo_flag_clear", resp_timeout, 1'b0);

        // ---------------- timeout: valid only at count 0 ----------------
        stub_mode = 2;
        issue(1'b1, 8'h40, 8'h40, 4'b0001, t);
        wait_resp(40, tr);
        check("stale_latency", tr - t,       TIMEOUT + 3);
        check("stale_flag",    resp_timeout, 1'b1);
        check("stale_data",    resp_data,    8'h00);
        check("stale_id",      resp_id,      1'b1);
        @(negedge clock);

        // ---------------- reset mid-operation ----------------
        stub_mode = 0;
        stub_lat  = 10;
        issue(1'b0, 8'h40, 8'h40, 4'b0001, t);  // now in LAUNCH
        @(negedge clock);                        // WAIT, count 0
        @(negedge clock);                        // WAIT, count 1
        reset = 1'b0;
        drive(1'b0, 8'h28, 8'h10, 4'b0001);
        @(negedge clock);
        #1;
        check("mid_rst_resp_valid", resp_valid,  1'b0);
        check("mid_rst_restart",    alu_restart, 1'b1);
        check("mid_rst_req0_ready", req0_ready,  1'b0);
        req0_valid = 1'b0;
        reset      = 1'b1;
        stub_lat   = 1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (resp_valid) seen++;
        end
        check("mid_rst_no_resp", seen, 0);
        issue(1'b1, 8'h28, 8'h10, 4'b0001, t);
        wait_resp(40, tr);
        check("mid_rst_new_latency", tr - t,    4);
        check("mid_rst_new_data",    resp_data, 8'h29);
        check("mid_rst_new_id",      resp_id,   1'b1);
        @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
